ball_engine: RTL and testbench



---
 rtl/pong_pkg.sv | 27 ++
 rtl/axis_reflect.sv | 32 +++
 rtl/ball_engine.sv | 163 ++++++++++++++++
 tb/tb_ball_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong types and default geometry for the ball engine, sender and receiver.
package pong_pkg;

  localparam int DefScreenW  = 640;
  localparam int DefScreenH  = 480;
  localparam int DefBallSize = 10;
  localparam int DefPosW     = 10;
  localparam int DefVelW     = 4;
  localparam int DefPaddleX  = 16;
  localparam int DefPaddleW  = 4;
  localparam int DefPaddleH  = 48;

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StHandoff,
    StMiss
  } ball_state_t;

  // Ball hand-off record exchanged with the link sender/receiver.
  typedef struct packed {
    logic        [DefPosW-1:0] y;
    logic        [DefVelW-1:0] vx;
    logic signed [DefVelW-1:0] vy;
  } ball_msg_t;

endpackage

// File: rtl/axis_reflect.sv
// One step along a single axis with mirror reflection at 0 and LIMIT.
module axis_reflect #(
  parameter int POS_W = 10,
  parameter int VEL_W = 4,
  parameter int LIMIT = 470
) (
  input  logic        [POS_W-1:0] pos,
  input  logic signed [VEL_W-1:0] vel,
  output logic        [POS_W-1:0] pos_next,
  output logic                    flip
);

  localparam int AW = POS_W + 2;

  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] lim;

  always_comb begin
    lim      = AW'(LIMIT);
    sum      = $signed({2'b00, pos}) + AW'(vel);
    flip     = 1'b0;
    pos_next = POS_W'(sum);
    if (sum < 0) begin
      pos_next = POS_W'(-sum);
      flip     = 1'b1;
    end else if (sum > lim) begin
      pos_next = POS_W'(lim + lim - sum);
      flip     = 1'b1;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Ball motion for one half of the Pong field: serve, paddle bounce, miss and right-edge hand-off.
// Define BALL_SPEEDUP_EN to add 1 to vx (saturating) on every paddle hit.
module ball_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W  = DefScreenW,
  parameter int SCREEN_H  = DefScreenH,
  parameter int BALL_SIZE = DefBallSize,
  parameter int POS_W     = DefPosW,
  parameter int VEL_W     = DefVelW,
  parameter int PADDLE_X  = DefPaddleX,
  parameter int PADDLE_W  = DefPaddleW,
  parameter int PADDLE_H  = DefPaddleH
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    frame_tick,
  input  logic        [POS_W-1:0] paddle_top,
  input  logic                    serve_valid,
  output logic                    serve_ready,
  input  logic                    serve_side,
  input  logic        [POS_W-1:0] serve_y,
  input  logic        [VEL_W-1:0] serve_vx,
  input  logic signed [VEL_W-1:0] serve_vy,
  output logic        [POS_W-1:0] ball_left,
  output logic        [POS_W-1:0] ball_top,
  output logic                    active,
  output logic                    hit,
  output logic                    handoff_valid,
  input  logic                    handoff_ready,
  output logic        [POS_W-1:0] handoff_y,
  output logic        [VEL_W-1:0] handoff_vx,
  output logic signed [VEL_W-1:0] handoff_vy,
  output logic                    miss_valid,
  input  logic                    miss_ready
);

  localparam int AW     = POS_W + 2;
  localparam int XMAX   = SCREEN_W - BALL_SIZE;
  localparam int YMAX   = SCREEN_H - BALL_SIZE;
  localparam int FACE   = PADDLE_X + PADDLE_W;
  localparam int VX_MAX = (1 << VEL_W) - 1;

  ball_state_t              state_q;
  logic        [POS_W-1:0]  left_q;
  logic        [POS_W-1:0]  top_q;
  logic        [VEL_W-1:0]  vx_q;
  logic signed [VEL_W-1:0]  vy_q;
  logic                     dir_right_q;
  logic                     hit_q;

  logic        [POS_W-1:0]  top_step;
  logic                     y_flip;
  logic signed [AW-1:0]     left_s;
  logic signed [AW-1:0]     vx_s;
  logic signed [AW-1:0]     nl_left;
  logic signed [AW-1:0]     nl_right;
  logic signed [AW-1:0]     top_post_s;
  logic signed [AW-1:0]     pad_s;
  logic                     overlap;
  logic                     cross_left;
  logic                     cross_right;
  logic        [VEL_W-1:0]  vx_hit;
  logic        [POS_W-1:0]  serve_top;
  logic        [VEL_W-1:0]  serve_vx_fix;

  axis_reflect #(
    .POS_W (POS_W),
    .VEL_W (VEL_W),
    .LIMIT (YMAX)
  ) u_y_axis (
    .pos      (top_q),
    .vel      (vy_q),
    .pos_next (top_step),
    .flip     (y_flip)
  );

  always_comb begin
    left_s      = $signed({2'b00, left_q});
    vx_s        = $signed({{(AW - VEL_W){1'b0}}, vx_q});
    nl_left     = left_s - vx_s;
    nl_right    = left_s + vx_s;
    // Paddle overlap uses the row after this tick's Y step.
    top_post_s  = $signed({2'b00, top_step});
    pad_s       = $signed({2'b00, paddle_top});
    overlap     = ((top_post_s + AW'(BALL_SIZE)) > pad_s) &&
                  (top_post_s < (pad_s + AW'(PADDLE_H)));
    cross_left  = nl_left <= AW'(FACE);
    cross_right = nl_right >= AW'(XMAX);
`ifdef BALL_SPEEDUP_EN
    vx_hit      = (vx_q == VEL_W'(VX_MAX)) ? vx_q : vx_q + 1'b1;
`else
    vx_hit      = vx_q;
`endif
    serve_top    = (serve_y > POS_W'(YMAX)) ? POS_W'(YMAX) : serve_y;
    serve_vx_fix = (serve_vx == '0) ? VEL_W'(1) : serve_vx;
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q     <= StIdle;
      left_q      <= '0;
      top_q       <= '0;
      vx_q        <= '0;
      vy_q        <= '0;
      dir_right_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (serve_valid) begin
            top_q       <= serve_top;
            vx_q        <= serve_vx_fix;
            vy_q        <= serve_vy;
            left_q      <= serve_side ? POS_W'(FACE) : POS_W'(XMAX);
            dir_right_q <= serve_side;
            state_q     <= StMove;
          end
        end
        StMove: begin
          if (frame_tick) begin
            top_q <= top_step;
            if (y_flip) vy_q <= -vy_q;
            if (!dir_right_q) begin
              if (!cross_left) begin
                left_q <= POS_W'(nl_left);
              end else if (overlap) begin
                left_q      <= POS_W'(FACE);
                dir_right_q <= 1'b1;
                vx_q        <= vx_hit;
                hit_q       <= 1'b1;
              end else begin
                left_q  <= '0;
                state_q <= StMiss;
              end
            end else if (cross_right) begin
              left_q  <= POS_W'(XMAX);
              state_q <= StHandoff;
            end else begin
              left_q <= POS_W'(nl_right);
            end
          end
        end
        StHandoff: if (handoff_ready) state_q <= StIdle;
        StMiss:    if (miss_ready) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign serve_ready   = (state_q == StIdle);
  assign active        = (state_q == StMove);
  assign handoff_valid = (state_q == StHandoff);
  assign miss_valid    = (state_q == StMiss);
  assign hit           = hit_q;
  assign ball_left     = left_q;
  assign ball_top      = top_q;
  assign handoff_y     = top_q;
  assign handoff_vx    = vx_q;
  assign handoff_vy    = vy_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: serve/step vector table plus bounce, miss and hand-off sequences.
module tb_ball_engine;

  logic              clock = 1'b0;
  logic              reset_L = 1'b0;
  logic              frame_tick = 1'b0;
  logic [9:0]        paddle_top = '0;
  logic              serve_valid = 1'b0;
  logic              serve_ready;
  logic              serve_side = 1'b0;
  logic [9:0]        serve_y = '0;
  logic [3:0]        serve_vx = '0;
  logic signed [3:0] serve_vy = '0;
  logic [9:0]        ball_left;
  logic [9:0]        ball_top;
  logic              active;
  logic              hit;
  logic              handoff_valid;
  logic              handoff_ready = 1'b0;
  logic [9:0]        handoff_y;
  logic [3:0]        handoff_vx;
  logic signed [3:0] handoff_vy;
  logic              miss_valid;
  logic              miss_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  ball_engine dut (
    .clock         (clock),
    .reset_L       (reset_L),
    .frame_tick    (frame_tick),
    .paddle_top    (paddle_top),
    .serve_valid   (serve_valid),
    .serve_ready   (serve_ready),
    .serve_side    (serve_side),
    .serve_y       (serve_y),
    .serve_vx      (serve_vx),
    .serve_vy      (serve_vy),
    .ball_left     (ball_left),
    .ball_top      (ball_top),
    .active        (active),
    .hit           (hit),
    .handoff_valid (handoff_valid),
    .handoff_ready (handoff_ready),
    .handoff_y     (handoff_y),
    .handoff_vx    (handoff_vx),
    .handoff_vy    (handoff_vy),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready)
  );

  typedef struct {
    bit side;
    int y;
    int vx;
    int vy;
    int ticks;
    int exp_left;
    int exp_top;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    @(posedge clock);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic serve(input bit side, input int y, input int vx, input int vy);
    serve_side  = side;
    serve_y     = 10'(y);
    serve_vx    = 4'(vx);
    serve_vy    = 4'(vy);
    serve_valid = 1'b1;
    @(posedge clock);
    #1;
    serve_valid = 1'b0;
  endtask

  // Holds frame_tick high for n consecutive edges.
  task automatic tick(input int n);
    if (n > 0) begin
      frame_tick = 1'b1;
      repeat (n) @(posedge clock);
      #1;
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    int exp_vx_hit;
    vecs[0] = '{side: 1'b0, y: 100, vx: 3,  vy: 2,  ticks: 1, exp_left: 627, exp_top: 102};
    vecs[1] = '{side: 1'b0, y: 1,   vx: 1,  vy: -3, ticks: 1, exp_left: 629, exp_top: 2};
    vecs[2] = '{side: 1'b0, y: 1,   vx: 1,  vy: -3, ticks: 2, exp_left: 628, exp_top: 5};
    vecs[3] = '{side: 1'b0, y: 500, vx: 2,  vy: 5,  ticks: 0, exp_left: 630, exp_top: 470};
    vecs[4] = '{side: 1'b0, y: 500, vx: 2,  vy: 5,  ticks: 1, exp_left: 628, exp_top: 465};
    vecs[5] = '{side: 1'b0, y: 50,  vx: 0,  vy: 0,  ticks: 3, exp_left: 627, exp_top: 50};
    vecs[6] = '{side: 1'b1, y: 200, vx: 5,  vy: -1, ticks: 2, exp_left: 30,  exp_top: 198};
    vecs[7] = '{side: 1'b0, y: 0,   vx: 15, vy: 0,  ticks: 4, exp_left: 570, exp_top: 0};
`ifdef BALL_SPEEDUP_EN
    exp_vx_hit = 4;
`else
    exp_vx_hit = 3;
`endif

    // Reset state
    do_reset();
    check("rst_left", ball_left, 0);
    check("rst_top", ball_top, 0);
    check("rst_active", active, 0);
    check("rst_hit", hit, 0);
    check("rst_hv", handoff_valid, 0);
    check("rst_mv", miss_valid, 0);
    check("rst_sready", serve_ready, 1);
    check("rst_hvx", handoff_vx, 0);
    check("rst_hvy", handoff_vy, 0);

    // Serve-and-step table
    paddle_top = 10'd0;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      serve(vecs[i].side, vecs[i].y, vecs[i].vx, vecs[i].vy);
      check($sformatf("v%0d_sready", i), serve_ready, 0);
      tick(vecs[i].ticks);
      check($sformatf("v%0d_left", i), ball_left, vecs[i].exp_left);
      check($sformatf("v%0d_top", i), ball_top, vecs[i].exp_top);
      check($sformatf("v%0d_active", i), active, 1);
      check($sformatf("v%0d_hit", i), hit, 0);
    end

    // Serve coinciding with frame_tick loads only; serve_valid ignored in MOVE
    do_reset();
    frame_tick = 1'b1;
    serve(1'b0, 100, 3, 2);
    frame_tick = 1'b0;
    check("cotick_left", ball_left, 630);
    check("cotick_top", ball_top, 100);
    serve(1'b1, 7, 9, 1);
    check("ignore_left", ball_left, 630);
    check("ignore_top", ball_top, 100);
    check("ignore_active", active, 1);

    // Paddle hit from the left approach
    do_reset();
    paddle_top = 10'd190;
    serve(1'b0, 200, 3, 0);
    tick(203);
    check("hit_pre_left", ball_left, 21);
    check("hit_pre_hit", hit, 0);
    tick(1);
    check("hit_left", ball_left, 20);
    check("hit_pulse", hit, 1);
    check("hit_active", active, 1);
    @(posedge clock);
    #1;
    check("hit_one_cycle", hit, 0);
    tick(1);
    check("hit_dir_right", ball_left, 20 + exp_vx_hit);

    // Y reflection and paddle hit on the same tick; vx 15 saturates
    do_reset();
    paddle_top = 10'd0;
    serve(1'b0, 40, 15, -1);
    tick(40);
    check("rhit_pre_left", ball_left, 30);
    check("rhit_pre_top", ball_top, 0);
    tick(1);
    check("rhit_left", ball_left, 20);
    check("rhit_top", ball_top, 1);
    check("rhit_pulse", hit, 1);
    tick(1);
    check("rhit_next_left", ball_left, 35);
    check("rhit_next_top", ball_top, 2);

    // Miss with delayed acknowledge
    do_reset();
    paddle_top = 10'd400;
    serve(1'b0, 200, 3, 0);
    tick(204);
    check("miss_valid", miss_valid, 1);
    check("miss_left", ball_left, 0);
    check("miss_active", active, 0);
    check("miss_hit", hit, 0);
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'(i & 1);
      @(posedge clock);
      #1;
      check($sformatf("miss_hold%0d", i), miss_valid, 1);
      check($sformatf("miss_hold_left%0d", i), ball_left, 0);
    end
    frame_tick = 1'b0;
    miss_ready = 1'b1;
    @(posedge clock);
    #1;
    miss_ready = 1'b0;
    check("miss_clear", miss_valid, 0);
    check("miss_sready", serve_ready, 1);

    // Hand-off at the right edge with delayed ready
    do_reset();
    serve(1'b1, 380, 15, -2);
    tick(40);
    check("ho_pre_left", ball_left, 620);
    check("ho_pre_top", ball_top, 300);
    check("ho_pre_valid", handoff_valid, 0);
    tick(1);
    check("ho_valid", handoff_valid, 1);
    check("ho_left", ball_left, 630);
    check("ho_active", active, 0);
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1;
      @(posedge clock);
      #1;
      check($sformatf("ho_hold_valid%0d", i), handoff_valid, 1);
      check($sformatf("ho_y%0d", i), handoff_y, 298);
      check($sformatf("ho_vx%0d", i), handoff_vx, 15);
      check($sformatf("ho_vy%0d", i), handoff_vy, -2);
    end
    frame_tick = 1'b0;
    handoff_ready = 1'b1;
    @(posedge clock);
    #1;
    handoff_ready = 1'b0;
    check("ho_clear", handoff_valid, 0);
    check("ho_sready", serve_ready, 1);

    // Reset wins over a frame_tick mid-MOVE; then a vx=0 serve steps by 1
    do_reset();
    serve(1'b0, 100, 3, 2);
    frame_tick = 1'b1;
    reset_L    = 1'b0;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
    reset_L    = 1'b1;
    check("mrst_left", ball_left, 0);
    check("mrst_top", ball_top, 0);
    check("mrst_active", active, 0);
    check("mrst_sready", serve_ready, 1);
    check("mrst_hit", hit, 0);
    serve(1'b0, 60, 0, 0);
    tick(1);
    check("vx0_step1", ball_left, 629);
    tick(1);
    check("vx0_step2", ball_left, 628);

    // Reset during a pending hand-off
    do_reset();
    serve(1'b1, 100, 15, 0);
    tick(41);
    check("horst_pre", handoff_valid, 1);
    reset_L = 1'b0;
    handoff_ready = 1'b0;
    @(posedge clock);
    #1;
    reset_L = 1'b1;
    check("horst_valid", handoff_valid, 0);
    check("horst_sready", serve_ready, 1);
    check("horst_vx", handoff_vx, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
